ifu_fetch_queue: RTL
====================

// Module: ifu_fetch_queue
// PURPOSE
//  Instruction fetch queue between the IFU and the decode stage (IDU).
//  Captures every {ifu_pc, ifu_inst} beat the IFU presents and returns it in order to decode.
//  The IFU has no ready input, so the queue backpressures it with an early stall signal.
//  A redirect/flush from the branch/exception logic empties the queue in one cycle.
// PARAMETERS
//  DEPTH       4   entries; power of two, >= 4
//  SKID        2   entries kept free for beats already in flight when ifq_stall rises; 1 <= SKID < DEPTH
//  PC_WIDTH    riscv_pkg::PC_WIDTH     fetch PC width
//  INST_WIDTH  riscv_pkg::INST_WIDTH   instruction width (32)
// PORTS
//  clk           in   1                     clock
//  rst           in   1                     synchronous, active-high reset
//  ifu_vld       in   1                     IFU beat valid
//  ifu_pc        in   PC_WIDTH              PC of beat
//  ifu_inst      in   INST_WIDTH            instruction of beat
//  ifq_stall     out  1                     IFU must stop issuing new beats
//  flush         in   1                     redirect: discard all queued and incoming beats
//  dec_vld       out  1                     head entry valid toward decode
//  dec_pc        out  PC_WIDTH              head PC
//  dec_inst      out  INST_WIDTH            head instruction
//  dec_rdy       in   1                     decode accepts head this cycle
//  ifq_count     out  $clog2(DEPTH+1)       current occupancy
//  ifq_ovf_err   out  1                     sticky: a beat arrived while full and was dropped
// BEHAVIOUR
//  Clock is clk; rst is synchronous and active-high.
//  Reset:
//  - count, wr_ptr and rd_ptr go to 0.
//  - dec_vld=0, ifq_stall=0, ifq_ovf_err=0.
//  - Storage array is not reset.
//  - Reset mid-operation discards all contents in the same way.
//  Pointers and count:
//  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
//  - count holds 0..DEPTH.
//  Push and pop:
//  - push = ifu_vld & ~flush & (count<DEPTH | pop).
//  - pop  = dec_vld & dec_rdy & ~flush.
//  - Push writes entry[wr_ptr] and advances wr_ptr. Pop advances rd_ptr.
//  - count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.
//  - A simultaneous push and pop is legal at full (DEPTH) and at empty is not possible
//    (pop needs dec_vld).
//  Output timing:
//  - Latency is 1 cycle: a beat pushed in cycle N is visible on dec_* in cycle N+1 at the earliest.
//  - There is no empty-bypass path.
//  - dec_vld = (count!=0); dec_pc/dec_inst = entry[rd_ptr]; all driven from registered state.
//  - dec_* are don't-care while dec_vld=0.
//  - Head is stable while dec_vld & ~dec_rdy & ~flush.
//  Stall and overflow:
//  - ifq_stall = (count >= DEPTH-SKID), from registered count only (no combinational path from ifu_vld).
//  - If ifu_vld & ~flush & count==DEPTH & ~pop, the beat is dropped and ifq_ovf_err sets.
//  - ifq_ovf_err stays set until rst. This is a protocol violation by the IFU.
//  Flush:
//  - Flush has priority over everything.
//  - count, wr_ptr and rd_ptr go to 0 next cycle.
//  - The ifu beat in the flush cycle is discarded and no pop is counted.
//  - dec_vld=0 in the cycle after flush. The redirected IFU stream refills normally.
//  Arithmetic:
//  - No state machine beyond pointers and count.
//  - count arithmetic is unsigned, $clog2(DEPTH+1) bits, and can never under- or overflow by construction.
// STRUCTURE
//  riscv_pkg holds:
//  - PC_WIDTH and INST_WIDTH
//  - typedef struct packed {logic[PC_WIDTH-1:0] pc; logic[INST_WIDTH-1:0] inst;} fetch_entry_t
//  Sub-module sync_fifo_flush #(WIDTH,DEPTH):
//  - generic storage, pointers, count, flush
//  - reusable by LSU/ROB queues
//  ifu_fetch_queue wraps it and adds stall, overflow and pack/unpack of fetch_entry_t.
// TESTING (DEPTH=4, SKID=2)
//  1. Reset, then ifu_vld=1 with pc=0x10, inst=0x00000013, dec_rdy=1
//     -> next cycle dec_vld=1, dec_pc=0x10, dec_inst=0x00000013, count=0 after pop.
//  2. dec_rdy=0, pcs 1,2,3,4 on consecutive cycles
//     -> ifq_stall=1 once count=2. Count reaches 4.
//     -> Then dec_rdy=1 drains pcs 1,2,3,4 in order, and ifq_stall drops at count=1.
//  3. Full (count=4), ifu_vld=1 pc=5 with dec_rdy=1
//     -> pc 5 accepted, pc 1 popped, count stays 4, ifq_ovf_err=0.
//  4. Full, ifu_vld=1 pc=6 with dec_rdy=0 -> pc 6 dropped, ifq_ovf_err=1 and stays set.
//  5. count=3, flush=1 with ifu_vld=1 pc=0x80
//     -> next cycle count=0, dec_vld=0.
//     -> pc 0x80 not stored; a subsequent push of pc=0x84 emerges first.
//  6. rst asserted for 1 cycle while count=2 -> next cycle dec_vld=0, count=0, ifq_stall=0, ifq_ovf_err=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   PC_WIDTH      : width of a fetch program counter
//   INST_WIDTH    : width of one instruction word
//   fetch_entry_t : one fetch beat as it sits in the fetch queue
package riscv_pkg;

    localparam int PC_WIDTH   = 32;
    localparam int INST_WIDTH = 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// Generic synchronous FIFO with single-cycle flush.
// Intended to be reused by the fetch, load/store and reorder queues.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_flush      : empties the FIFO next cycle; ignores this cycle's write and read
//   i_wr_vld     : write request (dropped when full and no read this cycle)
//   i_wr_data    : write data
//   i_rd_rdy     : consumer takes the head this cycle
//   o_rd_vld     : head valid (count != 0)
//   o_rd_data    : head data, from storage at the read pointer
//   o_count      : occupancy, 0..DEPTH
//   o_full       : occupancy equals DEPTH
//   o_pop        : a read happens this cycle
// Handshake: a read transfers on o_rd_vld & i_rd_rdy & ~i_flush. A write is
// taken on i_wr_vld & ~i_flush when there is room, where a same-cycle read
// counts as room. No empty bypass: written data shows up one cycle later.
module sync_fifo_flush #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_wr_vld,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_rdy,
    output logic                       o_rd_vld,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_pop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = (r_count != '0) & i_rd_rdy & ~i_flush;
    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push = i_wr_vld & ~i_flush & (~w_full | w_pop);

    // Pointers are power-of-two wide and simply wrap.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_vld  = (r_count != '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = w_full;
    assign o_pop     = w_pop;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue between the IFU and decode.
// Every valid IFU beat is captured and returned in order. The IFU has no
// ready input, so ifq_stall is raised early (SKID free entries left) to cover
// beats already in flight.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   ifu_vld/pc/inst      : incoming fetch beat
//   ifq_stall            : IFU must stop issuing (registered count only)
//   flush                : redirect; drops queue contents and this cycle's beat
//   dec_vld/pc/inst      : head entry toward decode
//   dec_rdy              : decode takes the head this cycle
//   ifq_count            : occupancy
//   ifq_ovf_err          : sticky; a beat arrived while full and was dropped
// Handshake: decode transfer on dec_vld & dec_rdy & ~flush; the head holds
// while dec_vld & ~dec_rdy & ~flush.
module ifu_fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SKID       = 2,
    parameter int PC_WIDTH   = riscv_pkg::PC_WIDTH,
    parameter int INST_WIDTH = riscv_pkg::INST_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ifu_vld,
    input  logic [PC_WIDTH-1:0]        ifu_pc,
    input  logic [INST_WIDTH-1:0]      ifu_inst,
    output logic                       ifq_stall,
    input  logic                       flush,
    output logic                       dec_vld,
    output logic [PC_WIDTH-1:0]        dec_pc,
    output logic [INST_WIDTH-1:0]      dec_inst,
    input  logic                       dec_rdy,
    output logic [$clog2(DEPTH+1)-1:0] ifq_count,
    output logic                       ifq_ovf_err
);

    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = $bits(fetch_entry_t);

    // The entry layout comes from riscv_pkg, so PC_WIDTH/INST_WIDTH must
    // match the package widths.
    fetch_entry_t     w_wr_entry;
    fetch_entry_t     w_rd_entry;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_pop;
    logic             r_ovf_err;

    assign w_wr_entry.pc   = ifu_pc;
    assign w_wr_entry.inst = ifu_inst;

    sync_fifo_flush #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_wr_vld  (ifu_vld),
        .i_wr_data (w_wr_entry),
        .i_rd_rdy  (dec_rdy),
        .o_rd_vld  (dec_vld),
        .o_rd_data (w_rd_entry),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_pop     (w_pop)
    );

    assign dec_pc    = w_rd_entry.pc;
    assign dec_inst  = w_rd_entry.inst;
    assign ifq_count = w_count;

    // Stall looks only at the registered count, never at ifu_vld.
    assign ifq_stall = (w_count >= CNT_W'(DEPTH - SKID));

    // A beat that meets a full queue with no pop is lost; remember it until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (ifu_vld && !flush && w_full && !w_pop) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign ifq_ovf_err = r_ovf_err;

endmodule
